// File: rtl/rr_int_pkg.sv
// rr_int_pkg: shared channel state encoding and default widths for the interrupt coalescer
package rr_int_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, REQ, WAIT_ACK} chan_st_e;
  localparam int DEF_NUM_INT   = 16;
  localparam int DEF_CNT_WIDTH = 16;
  localparam int DEF_TMO_WIDTH = 24;
  localparam int STAT_WIDTH    = 32;
endpackage

// File: rtl/rr_int_coalesce_chan.sv
// rr_int_coalesce_chan: one coalescing channel (FSM, event counter, flush timer, overflow); RR_INT_COALESCE_STATS_EN adds the cnt_o tap
module rr_int_coalesce_chan import rr_int_pkg::*; #(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int TMO_WIDTH = DEF_TMO_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 ev,
  input  logic                 ack,
  input  logic                 ovf_clr,
  input  logic [CNT_WIDTH-1:0] thr,
  input  logic [TMO_WIDTH-1:0] tmo,
  output logic                 req,
  output logic                 outst,
  output logic                 ovf
`ifdef RR_INT_COALESCE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] cnt_o
`endif
);
  chan_st_e st;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic [TMO_WIDTH-1:0] tmr, tmr_nx;
  logic fire, sat_ev;
`ifdef RR_INT_COALESCE_STATS_EN
  assign cnt_o = cnt;
`endif
  // saturating next count/timer, the fire decision and the saturated-event flag
  always_comb begin
    cnt_nx = (ev && !(&cnt)) ? cnt + CNT_WIDTH'(1) : cnt;
    tmr_nx = (&tmr) ? tmr : tmr + TMO_WIDTH'(1);
    fire   = enable && (cnt_nx >= thr || (tmo != '0 && tmr_nx >= tmo));
    sat_ev = ev && (&cnt) && (st == ACCUM || st == WAIT_ACK);
  end
  // channel FSM with registered req/outstanding; an event in REQ seeds the next batch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st    <= IDLE;
      cnt   <= '0;
      tmr   <= '0;
      req   <= 1'b0;
      outst <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      ovf <= sat_ev | (ovf & ~ovf_clr);
      case (st)
        IDLE: begin
          if (ev) begin
            st  <= ACCUM;
            cnt <= CNT_WIDTH'(1);
            tmr <= '0;
          end
        end
        ACCUM: begin
          cnt <= cnt_nx;
          tmr <= tmr_nx;
          req <= fire;
          if (fire) st <= REQ;
        end
        REQ: begin
          st    <= WAIT_ACK;
          cnt   <= CNT_WIDTH'(ev);
          tmr   <= '0;
          req   <= 1'b0;
          outst <= 1'b1;
        end
        WAIT_ACK: begin
          cnt <= cnt_nx;
          if (cnt != '0) tmr <= tmr_nx;
          if (ack) begin
            st    <= (cnt_nx != '0) ? ACCUM : IDLE;
            outst <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/rr_int_coalescer.sv
// rr_int_coalescer: per-channel event coalescing into int_req pulses; RR_INT_COALESCE_STATS_EN adds request/event/batch statistics
module rr_int_coalescer import rr_int_pkg::*; #(
  parameter int NUM_INT   = DEF_NUM_INT,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int TMO_WIDTH = DEF_TMO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [NUM_INT-1:0]    event_valid,
  input  logic [CNT_WIDTH-1:0]  threshold,
  input  logic [TMO_WIDTH-1:0]  timeout,
  output logic [NUM_INT-1:0]    int_req,
  input  logic [NUM_INT-1:0]    int_ack,
  output logic [NUM_INT-1:0]    outstanding,
  output logic [NUM_INT-1:0]    overflow,
  input  logic [NUM_INT-1:0]    overflow_clr
`ifdef RR_INT_COALESCE_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [STAT_WIDTH-1:0] stat_req_total,
  output logic [STAT_WIDTH-1:0] stat_event_total,
  output logic [CNT_WIDTH-1:0]  stat_max_batch
`endif
);
  logic [CNT_WIDTH-1:0] thr_eff;
  assign thr_eff = (threshold == '0) ? CNT_WIDTH'(1) : threshold;
`ifdef RR_INT_COALESCE_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_w [NUM_INT];
  logic [STAT_WIDTH-1:0] req_sum, ev_sum;
  logic [CNT_WIDTH-1:0] max_nx;
  // population counts of this cycle's requests/events and the running batch maximum
  always_comb begin
    req_sum = '0;
    ev_sum  = '0;
    max_nx  = stat_max_batch;
    for (int i = 0; i < NUM_INT; i++) begin
      req_sum = req_sum + STAT_WIDTH'(int_req[i]);
      ev_sum  = ev_sum + STAT_WIDTH'(event_valid[i]);
      max_nx  = (int_req[i] && cnt_w[i] > max_nx) ? cnt_w[i] : max_nx;
    end
  end
  // wrapping totals and batch maximum, synchronously cleared by stat_clr
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_req_total   <= '0;
      stat_event_total <= '0;
      stat_max_batch   <= '0;
    end else if (stat_clr) begin
      stat_req_total   <= '0;
      stat_event_total <= '0;
      stat_max_batch   <= '0;
    end else begin
      stat_req_total   <= stat_req_total + req_sum;
      stat_event_total <= stat_event_total + ev_sum;
      stat_max_batch   <= max_nx;
    end
  end
`endif
  for (genvar g = 0; g < NUM_INT; g++) begin : g_chan
    rr_int_coalesce_chan #(.CNT_WIDTH(CNT_WIDTH), .TMO_WIDTH(TMO_WIDTH)) u_chan (
      .clk     (clk),
      .rstn    (rstn),
      .enable  (enable),
      .ev      (event_valid[g]),
      .ack     (int_ack[g]),
      .ovf_clr (overflow_clr[g]),
      .thr     (thr_eff),
      .tmo     (timeout),
      .req     (int_req[g]),
      .outst   (outstanding[g]),
      .ovf     (overflow[g])
`ifdef RR_INT_COALESCE_STATS_EN
      ,
      .cnt_o   (cnt_w[g])
`endif
    );
  end
endmodule

// File: tb/tb_rr_int_coalescer.sv
// tb_rr_int_coalescer: scoreboard bench; expected (channel, cycle) of every int_req pushed at stimulus time
module tb_rr_int_coalescer;
  localparam int N = 16, CW = 16, TW = 24, SN = 8, SCW = 4;
  logic clk = 1'b0, rstn = 1'b0, enable = 1'b1;
  logic [N-1:0] event_valid = '0, int_ack = '0, overflow_clr = '0;
  logic [N-1:0] int_req, outstanding, overflow;
  logic [CW-1:0] threshold = CW'(1);
  logic [TW-1:0] timeout = '0;
  logic s_en = 1'b0;
  logic [SN-1:0] s_ev = '0, s_ack = '0, s_clr = '0, s_req, s_out, s_ovf;
  logic [SCW-1:0] s_thr = SCW'(10);
  logic [TW-1:0] s_tmo = '0;
  logic [31:0] sb[$];
  logic [N+SN-1:0] all_req;
  int cyc = 0, n_run = 0, n_fail = 0, p, a;

  rr_int_coalescer #(.NUM_INT(N), .CNT_WIDTH(CW), .TMO_WIDTH(TW)) u_dut (
    .clk(clk), .rstn(rstn), .enable(enable), .event_valid(event_valid),
    .threshold(threshold), .timeout(timeout), .int_req(int_req), .int_ack(int_ack),
    .outstanding(outstanding), .overflow(overflow), .overflow_clr(overflow_clr));

  rr_int_coalescer #(.NUM_INT(SN), .CNT_WIDTH(SCW), .TMO_WIDTH(TW)) u_sat (
    .clk(clk), .rstn(rstn), .enable(s_en), .event_valid(s_ev),
    .threshold(s_thr), .timeout(s_tmo), .int_req(s_req), .int_ack(s_ack),
    .outstanding(s_out), .overflow(s_ovf), .overflow_clr(s_clr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign all_req = {s_req, int_req};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_req(input int ch, input int at);
    sb.push_back({8'(ch), 24'(at)});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < N + SN; i++) begin
        if (all_req[i]) begin
          if (sb.size() == 0) chk("req_unexpected", {8'(i), 24'(cyc)}, 32'hffffffff);
          else chk("req", {8'(i), 24'(cyc)}, sb.pop_front());
        end
      end
    end
  end

  initial begin
    step(3);
    chk("rst_req", 32'(int_req), 0);
    chk("rst_outst", 32'(outstanding), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rstn = 1'b1;
    step(2);
    // threshold 4: four events on ch3, request right after the fourth
    threshold = CW'(4);
    p = cyc + 1;
    expect_req(3, p + 3);
    event_valid = 16'h0008;
    step(4);
    event_valid = '0;
    step(3);
    chk("t1_outst", 32'(outstanding[3]), 1);
    int_ack = 16'h0008;
    step(1);
    int_ack = '0;
    chk("t1_outst_clr", 32'(outstanding[3]), 0);
    // single event, flush by timeout 50
    threshold = CW'(100);
    timeout = TW'(50);
    p = cyc + 1;
    expect_req(0, p + 50);
    event_valid = 16'h0001;
    step(1);
    event_valid = '0;
    step(52);
    int_ack = 16'h0001;
    step(1);
    int_ack = '0;
    chk("t2_outst_clr", 32'(outstanding[0]), 0);
    timeout = '0;
    // five events during WAIT_ACK re-fire one cycle after the ack
    threshold = CW'(2);
    p = cyc + 1;
    expect_req(1, p + 1);
    event_valid = 16'h0002;
    step(2);
    event_valid = '0;
    step(1);
    event_valid = 16'h0002;
    step(5);
    event_valid = '0;
    chk("t3_outst", 32'(outstanding[1]), 1);
    a = cyc + 1;
    expect_req(1, a + 1);
    int_ack = 16'h0002;
    step(1);
    int_ack = '0;
    step(3);
    chk("t3_outst2", 32'(outstanding[1]), 1);
    int_ack = 16'h0002;
    step(1);
    int_ack = '0;
    chk("t3_outst_clr", 32'(outstanding[1]), 0);
    // event and ack together: event belongs to the next batch
    threshold = CW'(1);
    p = cyc + 1;
    expect_req(2, p + 1);
    event_valid = 16'h0004;
    step(1);
    event_valid = '0;
    step(2);
    a = cyc + 1;
    expect_req(2, a + 1);
    event_valid = 16'h0004;
    int_ack = 16'h0004;
    step(1);
    event_valid = '0;
    int_ack = '0;
    step(3);
    int_ack = 16'h0004;
    step(1);
    int_ack = '0;
    chk("t4_outst_clr", 32'(outstanding[2]), 0);
    // an event during the REQ cycle seeds the next batch
    p = cyc + 1;
    expect_req(4, p + 1);
    event_valid = 16'h0010;
    step(3);
    event_valid = '0;
    step(1);
    a = cyc + 1;
    expect_req(4, a + 1);
    int_ack = 16'h0010;
    step(1);
    int_ack = '0;
    step(3);
    int_ack = 16'h0010;
    step(1);
    int_ack = '0;
    chk("t4b_outst_clr", 32'(outstanding[4]), 0);
    // threshold 0 behaves as 1
    threshold = '0;
    p = cyc + 1;
    expect_req(6, p + 1);
    event_valid = 16'h0040;
    step(1);
    event_valid = '0;
    step(3);
    int_ack = 16'h0040;
    step(1);
    int_ack = '0;
    chk("thr0_outst_clr", 32'(outstanding[6]), 0);
    // 4-bit counter saturates while disabled; overflow set wins over clear
    s_ev = 8'h80;
    step(20);
    s_ev = '0;
    chk("t5_ovf", 32'(s_ovf[7]), 1);
    chk("t5_no_outst", 32'(s_out[7]), 0);
    s_ev = 8'h80;
    s_clr = 8'h80;
    step(1);
    s_ev = '0;
    s_clr = '0;
    chk("t5_set_wins", 32'(s_ovf[7]), 1);
    s_clr = 8'h80;
    step(1);
    s_clr = '0;
    chk("t5_ovf_clr", 32'(s_ovf[7]), 0);
    expect_req(N + 7, cyc + 1);
    s_en = 1'b1;
    step(3);
    chk("t5_outst", 32'(s_out[7]), 1);
    s_ack = 8'h80;
    step(1);
    s_ack = '0;
    chk("t5_outst_clr", 32'(s_out[7]), 0);
    s_en = 1'b0;
    // async reset with one channel outstanding, the rest mid-batch, and an overflow set
    threshold = CW'(1);
    p = cyc + 1;
    expect_req(15, p + 1);
    event_valid = 16'h8000;
    step(1);
    event_valid = '0;
    step(2);
    chk("t6_pre_outst", 32'(outstanding), 32'h8000);
    threshold = CW'(100);
    event_valid = 16'h7fff;
    s_ev = 8'h01;
    step(17);
    event_valid = '0;
    s_ev = '0;
    chk("t6_pre_ovf", 32'(s_ovf[0]), 1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_outst", 32'(outstanding), 0);
    chk("t6_req", 32'(int_req), 0);
    chk("t6_sat_ovf", 32'(s_ovf), 0);
    step(2);
    rstn = 1'b1;
    threshold = CW'(1);
    s_thr = SCW'(1);
    s_en = 1'b1;
    step(10);
    chk("t6_sat_outst", 32'(s_out), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_int_coalescer.md
Name: rr_int_coalescer

Overview:
- Upstream neighbour of rr_int_to_pcim.
- Collects per-channel record/replay events (buffer-threshold crossings, log-full, replay-done) and coalesces them into one interrupt per batch.
- Drives int_req into the PCIM interrupt writer and consumes its int_ack.
- Bounds host interrupt rate with a per-channel count threshold and a flush timeout.

Parameters:
- NUM_INT, 16, number of interrupt channels; must match the downstream writer.
- CNT_WIDTH, 16, width of the per-channel event counter and of threshold.
- TMO_WIDTH, 24, width of the per-channel flush timer and of timeout.

Ports:
- clk  in  1  single clock.
- rstn  in  1  reset; asynchronous assert, active-low.
- enable  in  1  global request enable.
- event_valid  in  NUM_INT  one event per set bit per cycle.
- threshold  in  CNT_WIDTH  batch size that triggers a request; 0 is treated as 1.
- timeout  in  TMO_WIDTH  cycles after the first event of a batch before a forced flush; 0 disables the timer.
- int_req  out  NUM_INT  one-cycle request pulse per channel, to rr_int_to_pcim.
- int_ack  in  NUM_INT  one-cycle acknowledge pulse per channel, from rr_int_to_pcim.
- outstanding  out  NUM_INT  channel is waiting for an ack.
- overflow  out  NUM_INT  sticky: an event arrived while the counter was saturated.
- overflow_clr  in  NUM_INT  clears the corresponding overflow bits.

Behaviour:
- Reset (async, rstn=0): all outputs 0, all counters and timers 0, every channel in IDLE. Reset mid-batch discards all pending events; no int_req is emitted.
- Per-channel FSM, registered:
  - IDLE: cnt==0. An event moves to ACCUM with cnt=1 and tmr=0.
  - ACCUM: cnt += event (saturates at all-ones); tmr += 1 (saturates).
    - Fire when enable=1 and (cnt_next >= max(threshold,1) or (timeout!=0 and tmr_next >= timeout)). Go to REQ.
  - REQ: lasts exactly one cycle. int_req[i]=1; cnt and tmr reset.
    - An event in this cycle starts the next batch: cnt=1.
    - Next state: WAIT_ACK.
  - WAIT_ACK: outstanding[i]=1. Events keep accumulating; tmr runs only if cnt>0.
    - On int_ack[i]: go to ACCUM if cnt>0 (or an event this cycle), else IDLE.
    - The fire check is re-evaluated on the next ACCUM cycle, so a full batch re-fires one cycle later.
- Latency: the event that satisfies threshold in cycle N produces int_req in cycle N+1.
- Never more than one outstanding request per channel.
- int_ack is honoured only in WAIT_ACK; in any other state it is ignored.
- Event and ack in the same cycle: the event is counted in the post-ack batch.
- enable=0: events still counted; no new REQ; a WAIT_ACK in progress still completes on ack. On re-enable, the fire check applies immediately.
- Threshold/timeout changes take effect on the next cycle's compare; no batch restart.
- Saturation: event while cnt is all-ones sets overflow[i]. overflow_clr[i] clears the bit; a set in the same cycle wins over the clear.
- Channels are independent. Several int_req bits may pulse in the same cycle; the downstream stage serialises them.

Optional Feature:
- Macro: RR_INT_COALESCE_STATS_EN.
- Defined:
  - Adds outputs stat_req_total (32 bit), stat_event_total (32 bit) and stat_max_batch (CNT_WIDTH bit).
  - stat_req_total counts int_req pulses over all channels.
  - stat_event_total counts accepted events over all channels; both wrap at 2^32.
  - stat_max_batch holds the largest cnt at REQ time.
  - All three reset to 0 and clear synchronously on input stat_clr.
- Undefined: none of these ports or registers exist. Core behaviour is identical.

Decomposition:
- Package rr_int_pkg: channel state enum (IDLE, ACCUM, REQ, WAIT_ACK), default widths, STAT_WIDTH=32.
- Sub-module rr_int_coalesce_chan holds one channel (FSM, counter, timer, overflow); the top generates NUM_INT copies.
- Top holds the stats logic and the effective-threshold mux shared by all channels.

Test Plan:
1. threshold=4, timeout=0, four events on ch3 in cycles 10-13 -> int_req[3] pulse at cycle 14 only; outstanding[3]=1 until the ack pulse, then 0.
2. threshold=100, timeout=50, single event ch0 at cycle 5 -> int_req[0] at cycle 56; no other req.
3. threshold=2, ch1 in WAIT_ACK receives 5 events, then ack -> ACCUM, int_req[1] two cycles after the ack; cnt at REQ = 5.
4. Event and ack on ch2 in the same cycle in WAIT_ACK -> next batch cnt=1, no lost event; with threshold=1, req two cycles later.
5. CNT_WIDTH=4 override, enable=0, 20 events ch7 -> cnt=15, overflow[7]=1; overflow_clr pulse -> 0; enable=1 -> int_req[7] next cycle.
6. Assert rstn mid-ACCUM on all channels -> outputs 0 immediately (async); after release, no req without new events.
